key_conditioner: RTL and testbench
==================================

Name: key_conditioner

Overview:
- Input conditioning stage directly upstream of the game control block.
- Converts the four raw, asynchronous, bouncy lane buttons into clean, synchronous per-lane levels. These levels drive the game control inputs key0..key3.
- Also produces one-cycle press/release pulses for judgement timing and a saturating total-press counter for end-of-song statistics.
- All four lanes are identical and independent.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a synchronized input must differ from the stable state before the stable state flips. 10 ms at 100 MHz. Legal range 1..2^CNT_W-1.
- CNT_W, 20, width of each per-lane debounce counter.
- KEY_ACTIVE_LOW, 0, 1 = raw buttons read 0 when pressed. Inversion is applied before the first synchronizer flop.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- key_raw  in  4  raw lane buttons; bit n = lane n; asynchronous to clk
- key_level  out  4  debounced pressed level per lane (1 = pressed); drives game control key0..key3
- key_press  out  4  one-cycle pulse when the lane's key_level goes 0->1
- key_release  out  4  one-cycle pulse when the lane's key_level goes 1->0
- press_count  out  16  total debounced presses since reset, saturating

Behaviour:
Reset
- One clock; reset is asynchronous and active-high.
- While rst=1, every register clears immediately, independent of clk: synchronizer flops, counters, key_level, key_press, key_release and press_count all = 0.
- Synchronizer flops reset to the inactive level (0 after polarity correction).

Per lane n
- Polarity: k_n = key_raw[n] XOR KEY_ACTIVE_LOW.
- Synchronizer: k_n feeds a 2-flop chain, sync1 -> sync2.
- Debounce, on each edge:
  - if sync2 == key_level[n]: counter clears to 0.
  - else if counter == DEBOUNCE_CYCLES-1: key_level[n] <= sync2 and counter <= 0.
  - else: counter increments.
- Latency: if k_n goes high before edge 1 and stays high, key_level[n] and key_press[n] are high after edge DEBOUNCE_CYCLES+2. Release has the same latency.
- Glitch rejection: any return of sync2 to key_level[n] before qualification clears the counter. No output change results.
- key_press[n] / key_release[n] are registered on the same edge that flips key_level[n]. Each is high for exactly one cycle, in the first cycle the new level is visible. Press and release never assert together on one lane.
- DEBOUNCE_CYCLES=1: a single cycle of differing sync2 qualifies.

Cross-lane
- Lanes are fully independent. Simultaneous qualifications produce pulses in the same cycle.
- press_count <= min(press_count + popcount(key_press_next), 16'hFFFF).
  - Adds 0..4 per cycle, updating on the same edge as the pulses.
  - Sum is computed 17 bits wide; any overflow clamps to 16'hFFFF and holds there until reset.
  - Releases do not change press_count.

Reset mid-operation
- A partial count is discarded.
- A key held through reset deassertion is treated as newly pressed: full synchronizer plus debounce latency, then key_press fires and press_count = 1.
- No output pulse is ever generated by reset itself.

Test Plan:
1. Reset: rst=1 with key_raw=4'b1111 (KEY_ACTIVE_LOW=0) -> all outputs 0 and remain 0 while rst=1. Deassert rst -> key_level=4'b1111 with key_press=4'b1111 after edge 6, press_count=4.
2. Single press, DEBOUNCE_CYCLES=4: key_raw[0]=1 before edge 1, held -> key_level[0]=1 and key_press[0]=1 after edge 6; key_press[0]=0 after edge 7; press_count=1.
3. Glitch: key_raw[1]=1 for 3 cycles then 0 (DEBOUNCE_CYCLES=4) -> key_level[1], key_press[1] stay 0; press_count unchanged. Repeat with a 1-cycle dropout inside a held press -> no release pulse.
4. Simultaneous press and release: key_raw 0000->1111 -> one cycle with key_press=1111, press_count +4. Then 1111->0000 -> key_release=1111 for one cycle, press_count unchanged.
5. Saturation, DEBOUNCE_CYCLES=1: toggle all four lanes 16384+ times -> press_count reaches 16'hFFFF and holds; a final 4-lane press from 16'hFFFD yields 16'hFFFF, not a wrap.
6. Active-low, KEY_ACTIVE_LOW=1: key_raw idle 1111, lane 2 driven 0 -> key_level[2]=1 after edge 6. Assert rst mid-debounce (edge 3) -> counter discarded; after deassert, full 6-edge latency restarts.

Source files
------------

// File: rtl/key_conditioner.sv
// Conditions four raw lane buttons into synchronous, debounced levels,
// one-cycle press/release pulses and a saturating total-press counter.
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter bit          KEY_ACTIVE_LOW  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_raw,
  output logic [3:0]  key_level,
  output logic [3:0]  key_press,
  output logic [3:0]  key_release,
  output logic [15:0] press_count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       k;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [CNT_W-1:0] cnt      [4];
  logic [CNT_W-1:0] cnt_next [4];
  logic [3:0]       level_next;
  logic [3:0]       press_next;
  logic [3:0]       release_next;
  logic [2:0]       n_press;
  logic [16:0]      sum;
  logic [15:0]      count_next;

  // Polarity is corrected ahead of the first synchronizer flop.
  assign k = key_raw ^ {4{KEY_ACTIVE_LOW}};

  always_comb begin
    level_next   = key_level;
    press_next   = '0;
    release_next = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != key_level[i]) begin
        if (cnt[i] == LAST) begin
          level_next[i]   = sync2[i];
          press_next[i]   = sync2[i];
          release_next[i] = ~sync2[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Sum carried to 17 bits so any overflow clamps instead of wrapping.
  always_comb begin
    n_press = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      n_press = n_press + 3'(press_next[i]);
    end
    sum        = {1'b0, press_count} + 17'(n_press);
    count_next = sum[16] ? '1 : sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1       <= '0;
      sync2       <= '0;
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      press_count <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1       <= k;
      sync2       <= sync1;
      key_level   <= level_next;
      key_press   <= press_next;
      key_release <= release_next;
      press_count <= count_next;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: main instance (4-cycle debounce),
// a 1-cycle instance for saturation and an active-low instance.
module tb_key_conditioner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_s, rst_l;
  logic [3:0]  raw_a, raw_s, raw_l;
  logic [3:0]  level_a, press_a, release_a;
  logic [3:0]  level_s, press_s, release_s;
  logic [3:0]  level_l, press_l, release_l;
  logic [15:0] count_a, count_s, count_l;

  int errors = 0;
  int checks = 0;

  key_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(20), .KEY_ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst(rst_a), .key_raw(raw_a), .key_level(level_a),
    .key_press(press_a), .key_release(release_a), .press_count(count_a)
  );

  key_conditioner #(.DEBOUNCE_CYCLES(1), .CNT_W(4), .KEY_ACTIVE_LOW(1'b0)) u_sat (
    .clk(clk), .rst(rst_s), .key_raw(raw_s), .key_level(level_s),
    .key_press(press_s), .key_release(release_s), .press_count(count_s)
  );

  key_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(8), .KEY_ACTIVE_LOW(1'b1)) u_low (
    .clk(clk), .rst(rst_l), .key_raw(raw_l), .key_level(level_l),
    .key_press(press_l), .key_release(release_l), .press_count(count_l)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_s = 1'b1; rst_l = 1'b1;
    raw_a = 4'hF; raw_s = 4'h0; raw_l = 4'hF;

    // Reset with all keys held
    tick(3);
    check("rst_level", 16'(level_a), 16'h0);
    check("rst_press", 16'(press_a), 16'h0);
    check("rst_release", 16'(release_a), 16'h0);
    check("rst_count", count_a, 16'h0);
    tick(2);
    check("rst_level_hold", 16'(level_a), 16'h0);
    rst_a = 1'b0;
    tick(5);
    check("held_lvl_e5", 16'(level_a), 16'h0);
    tick(1);
    check("held_lvl_e6", 16'(level_a), 16'hF);
    check("held_press_e6", 16'(press_a), 16'hF);
    check("held_count_e6", count_a, 16'd4);
    tick(1);
    check("held_press_e7", 16'(press_a), 16'h0);
    check("held_count_e7", count_a, 16'd4);

    // Release all
    raw_a = 4'h0;
    tick(5);
    check("rel_lvl_e5", 16'(level_a), 16'hF);
    tick(1);
    check("rel_lvl_e6", 16'(level_a), 16'h0);
    check("rel_pulse_e6", 16'(release_a), 16'hF);
    check("rel_press_e6", 16'(press_a), 16'h0);
    tick(1);
    check("rel_pulse_e7", 16'(release_a), 16'h0);
    check("rel_count", count_a, 16'd4);

    // Single press on lane 0
    raw_a = 4'b0001;
    tick(5);
    check("one_lvl_e5", 16'(level_a), 16'h0);
    tick(1);
    check("one_lvl_e6", 16'(level_a), 16'h1);
    check("one_press_e6", 16'(press_a), 16'h1);
    check("one_count_e6", count_a, 16'd5);
    tick(1);
    check("one_press_e7", 16'(press_a), 16'h0);

    // Three-cycle glitch on lane 1 is rejected
    raw_a = 4'b0011;
    tick(3);
    raw_a = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("glitch_lvl", 16'(level_a), 16'h1);
      check("glitch_press", 16'(press_a), 16'h0);
    end
    check("glitch_count", count_a, 16'd5);

    // One-cycle dropout inside a held press
    raw_a = 4'b0000;
    tick(1);
    raw_a = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("drop_lvl", 16'(level_a), 16'h1);
      check("drop_release", 16'(release_a), 16'h0);
    end

    // Simultaneous press and release
    raw_a = 4'b0000;
    tick(6);
    check("sim_pre_rel", 16'(release_a), 16'h1);
    tick(2);
    raw_a = 4'hF;
    tick(5);
    check("sim_press_e5", 16'(press_a), 16'h0);
    tick(1);
    check("sim_press_e6", 16'(press_a), 16'hF);
    check("sim_count_e6", count_a, 16'd9);
    tick(1);
    check("sim_press_e7", 16'(press_a), 16'h0);
    raw_a = 4'h0;
    tick(6);
    check("sim_rel_e6", 16'(release_a), 16'hF);
    check("sim_rel_press", 16'(press_a), 16'h0);
    check("sim_rel_count", count_a, 16'd9);
    tick(1);
    check("sim_rel_e7", 16'(release_a), 16'h0);

    // Active-low instance
    rst_l = 1'b0;
    tick(8);
    check("low_idle_lvl", 16'(level_l), 16'h0);
    check("low_idle_count", count_l, 16'd0);
    raw_l = 4'b1011;
    tick(5);
    check("low_lvl_e5", 16'(level_l), 16'h0);
    tick(1);
    check("low_lvl_e6", 16'(level_l), 16'h4);
    check("low_press_e6", 16'(press_l), 16'h4);
    check("low_count_e6", count_l, 16'd1);
    raw_l = 4'hF;
    tick(8);
    check("low_rel_lvl", 16'(level_l), 16'h0);
    check("low_rel_count", count_l, 16'd1);

    // Reset mid-debounce discards the partial count
    raw_l = 4'b1011;
    tick(3);
    rst_l = 1'b1;
    #1;
    check("low_async_count", count_l, 16'd0);
    check("low_async_lvl", 16'(level_l), 16'h0);
    tick(2);
    check("low_rst_press", 16'(press_l), 16'h0);
    rst_l = 1'b0;
    tick(5);
    check("low_rs_lvl_e5", 16'(level_l), 16'h0);
    tick(1);
    check("low_rs_lvl_e6", 16'(level_l), 16'h4);
    check("low_rs_press_e6", 16'(press_l), 16'h4);
    check("low_rs_count", count_l, 16'd1);
    tick(1);
    check("low_rs_press_e7", 16'(press_l), 16'h0);

    // Saturation with single-cycle debounce
    rst_s = 1'b0;
    tick(1);
    for (int i = 0; i < 16383; i++) begin
      raw_s = 4'hF;
      tick(1);
      raw_s = 4'h0;
      tick(1);
    end
    tick(5);
    check("sat_count_fffc", count_s, 16'hFFFC);
    raw_s = 4'b0001;
    tick(5);
    check("sat_count_fffd", count_s, 16'hFFFD);
    raw_s = 4'h0;
    tick(5);
    raw_s = 4'hF;
    tick(2);
    check("sat_d1_press_e2", 16'(press_s), 16'h0);
    tick(1);
    check("sat_d1_press_e3", 16'(press_s), 16'hF);
    check("sat_clamp", count_s, 16'hFFFF);
    raw_s = 4'h0;
    tick(5);
    check("sat_hold_rel", count_s, 16'hFFFF);
    raw_s = 4'hF;
    tick(5);
    check("sat_hold_press", count_s, 16'hFFFF);
    check("sat_level", 16'(level_s), 16'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
